// File: rtl/simd_pkg.sv
// Types and constants shared by the SIMD pipeline front end (fetch and decode).
package simd_pkg;

  localparam int INSTR_W = 25;

  typedef logic [INSTR_W-1:0] instr_t;

  // R3 format, opcode nop
  localparam instr_t NOP_INSTR = 25'h1800000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_buf.sv
// Program store: DEPTH x INSTR_W register array, synchronous write, combinational read.
// No reset on the contents, so a program survives a pipeline reset.
module instr_buf
  import simd_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [AW-1:0]      waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [AW-1:0]      raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  instr_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: loads a program serially, then issues one instruction per unstalled cycle (1-cycle start latency).
// Stall freezes the issue register and pc; optional RUN stall counter enabled by IFETCH_STALL_CNT_EN.
module instr_fetch
  import simd_pkg::*;
#(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_valid,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               start,
  input  logic               stall,
  output logic [INSTR_W-1:0] instructionIF,
  output logic               valid_IF,
  output logic [AW-1:0]      pc,
  output logic               done,
  output logic               overflow
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  localparam logic [AW:0] ONE_C   = 1;
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  fetch_state_t state_q;
  logic [AW:0]  count_q;
  logic [AW-1:0] pc_q;
  instr_t       instr_q;
  logic         valid_q;
  logic         done_q;
  logic         ovf_q;

  logic         buf_we;
  logic [AW-1:0] buf_waddr;
  instr_t       buf_rdata;
  logic         full;
  logic         last_issue;
  logic         go_run;

  assign full       = (count_q == DEPTH_C);
  // pc is one bit narrower than count so a full buffer's last index is DEPTH-1
  assign last_issue = ({1'b0, pc_q} == (count_q - ONE_C));
  assign go_run     = start && ((state_q == LOAD) ||
                                (state_q == IDLE && (load_valid || count_q != '0)));

  always_comb begin
    buf_we    = 1'b0;
    buf_waddr = '0;
    if (load_valid) begin
      case (state_q)
        IDLE, DONE: buf_we = 1'b1;
        LOAD: begin
          buf_we    = !full;
          buf_waddr = count_q[AW-1:0];
        end
        default: buf_we = 1'b0;
      endcase
    end
  end

  instr_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
    .clk_i   (clk),
    .we_i    (buf_we),
    .waddr_i (buf_waddr),
    .wdata_i (load_data),
    .raddr_i (pc_q),
    .rdata_o (buf_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            count_q <= ONE_C;
            state_q <= start ? RUN : LOAD;
            pc_q    <= '0;
          end else if (start) begin
            state_q <= (count_q == '0) ? DONE : RUN;
            pc_q    <= '0;
          end
        end
        LOAD: begin
          if (load_valid) begin
            if (full) ovf_q   <= 1'b1;
            else      count_q <= count_q + ONE_C;
          end
          if (start) begin
            state_q <= RUN;
            pc_q    <= '0;
          end
        end
        RUN: begin
          if (!stall) begin
            instr_q <= buf_rdata;
            valid_q <= 1'b1;
            pc_q    <= pc_q + 1'b1;
            if (last_issue) state_q <= DONE;
          end
        end
        DONE: begin
          if (!stall) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
          end
          // a new load starts a fresh program and wins over the done update
          if (load_valid) begin
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= ONE_C;
            state_q <= LOAD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef IFETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (go_run) begin
      stall_cnt_q <= '0;
    end else if (state_q == RUN && stall && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assign instructionIF = instr_q;
  assign valid_IF      = valid_q;
  assign pc            = pc_q;
  assign done          = done_q;
  assign overflow      = ovf_q;

endmodule
